execute_stage: RTL and testbench

- Execute stage of the RV32E(M) pipeline. Sits directly downstream of the ID/EX register and consumes its outputs.
- Selects ALU operands, runs single-cycle integer ALU ops and an iterative radix-2 multiply/divide unit, then drives the EX/MEM result register.
- Asserts stall_EX back to the front of the pipeline while a multiply/divide is in flight.

---
 rtl/execute_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_execute_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage of the RV32E(M) pipeline: operand select, single-cycle ALU,
// iterative radix-2 multiply/divide, and the EX/MEM result register.
module execute_stage #(
  parameter int unsigned MULDIV_EN     = 1,
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc0_EX,
  input  logic [31:0] pc4_EX,
  input  logic [3:0]  rd_EX,
  input  logic [3:0]  alu_operation_EX,
  input  logic        muldiv_EX,
  input  logic        regfile_we_EX,
  input  logic        alu_a_sel_EX,
  input  logic        alu_b_sel_EX,
  input  logic [31:0] immediate_EX,
  input  logic [31:0] rs1_data_EX,
  input  logic [31:0] rs2_data_EX,
  output logic        stall_EX,
  output logic [31:0] result_MEM,
  output logic [3:0]  rd_MEM,
  output logic        regfile_we_MEM
);

  localparam int unsigned CNT_W = $clog2(MULDIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_CYCLES - 1);

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [31:0] alu_calc(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [4:0]         shamt;
    sa    = signed'(a);
    sb    = signed'(b);
    shamt = b[4:0];
    case (op)
      ALU_ADD:    alu_calc = a + b;
      ALU_SUB:    alu_calc = a - b;
      ALU_SLL:    alu_calc = a << shamt;
      ALU_SLT:    alu_calc = {31'b0, sa < sb};
      ALU_SLTU:   alu_calc = {31'b0, a < b};
      ALU_XOR:    alu_calc = a ^ b;
      ALU_SRL:    alu_calc = a >> shamt;
      ALU_SRA:    alu_calc = 32'(sa >>> shamt);
      ALU_OR:     alu_calc = a | b;
      ALU_AND:    alu_calc = a & b;
      ALU_PASS_B: alu_calc = b;
      default:    alu_calc = '0;
    endcase
  endfunction

  // The iteration works on magnitudes; signs and divide-by-zero are resolved here.
  function automatic logic [31:0] muldiv_fixup(input logic [2:0]  f,
                                               input logic [31:0] hi,
                                               input logic [31:0] lo,
                                               input logic        a_neg,
                                               input logic        b_neg,
                                               input logic        b_zero,
                                               input logic [31:0] a_orig);
    logic [63:0] prod;
    prod = {hi, lo};
    if (a_neg ^ b_neg) prod = -prod;
    if (!f[2])       muldiv_fixup = (f == 3'd0) ? prod[31:0] : prod[63:32];
    else if (b_zero) muldiv_fixup = f[1] ? a_orig : '1;
    else if (!f[1])  muldiv_fixup = (a_neg ^ b_neg) ? -lo : lo;
    else             muldiv_fixup = a_neg ? -hi : hi;
  endfunction

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        md_f;
  logic [3:0]        md_rd;
  logic              md_we;
  logic [31:0]       acc_hi;
  logic [31:0]       acc_lo;
  logic [31:0]       mcand;
  logic [31:0]       a_orig;
  logic              a_neg;
  logic              b_neg;
  logic              b_zero;

  logic              start;
  logic [2:0]        f_in;
  logic              sgn_a_in;
  logic              sgn_b_in;
  logic              neg_a_in;
  logic              neg_b_in;
  logic [31:0]       abs_a_in;
  logic [31:0]       abs_b_in;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [31:0]       alu_result;
  logic [32:0]       mul_sum;
  logic [32:0]       div_shift;
  logic [32:0]       div_diff;
  logic [31:0]       step_hi;
  logic [31:0]       step_lo;
  logic [31:0]       wb_result;
  logic [3:0]        wb_rd;
  logic              wb_we;
  logic              unused_pc4;

  assign unused_pc4 = ^pc4_EX;

  // EX: operand select and single-cycle ALU
  assign op_a       = alu_a_sel_EX ? pc0_EX : rs1_data_EX;
  assign op_b       = alu_b_sel_EX ? immediate_EX : rs2_data_EX;
  assign alu_result = alu_calc(alu_operation_EX, op_a, op_b);

  assign start = (MULDIV_EN != 0) && muldiv_EX && regfile_we_EX && (rd_EX != 4'd0);

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
  assign f_in     = alu_operation_EX[2:0];
  assign sgn_a_in = (f_in == 3'd1) || (f_in == 3'd2) || (f_in == 3'd4) || (f_in == 3'd6);
  assign sgn_b_in = (f_in == 3'd1) || (f_in == 3'd4) || (f_in == 3'd6);
  assign neg_a_in = sgn_a_in && rs1_data_EX[31];
  assign neg_b_in = sgn_b_in && rs2_data_EX[31];
  assign abs_a_in = neg_a_in ? (32'd0 - rs1_data_EX) : rs1_data_EX;
  assign abs_b_in = neg_b_in ? (32'd0 - rs2_data_EX) : rs2_data_EX;

  // Muldiv iteration: shift-add multiply or restoring divide, one bit per cycle
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : 33'd0);
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_diff  = div_shift - {1'b0, mcand};

  always_comb begin
    step_hi = acc_hi;
    step_lo = acc_lo;
    if (!md_f[2]) begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo[31:1]};
    end else if (!div_diff[32]) begin
      step_hi = div_diff[31:0];
      step_lo = {acc_lo[30:0], 1'b1};
    end else begin
      step_hi = div_shift[31:0];
      step_lo = {acc_lo[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_orig <= rs1_data_EX;
      a_neg  <= neg_a_in;
      b_neg  <= neg_b_in;
      b_zero <= (rs2_data_EX == 32'd0);
      acc_hi <= '0;
      if (f_in[2]) begin
        acc_lo <= abs_a_in;
        mcand  <= abs_b_in;
      end else begin
        acc_lo <= abs_b_in;
        mcand  <= abs_a_in;
      end
    end else if (state == BUSY) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (cnt == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign stall_EX = rst_n && ((state == BUSY) || (state == IDLE && start));

  always_comb begin
    wb_result = '0;
    wb_rd     = '0;
    wb_we     = 1'b0;
    case (state)
      IDLE: begin
        if (!start) begin
          wb_result = muldiv_EX ? 32'd0 : alu_result;
          wb_rd     = rd_EX;
          wb_we     = regfile_we_EX;
        end
      end
      DONE: begin
        wb_result = muldiv_fixup(md_f, acc_hi, acc_lo, a_neg, b_neg, b_zero, a_orig);
        wb_rd     = md_rd;
        wb_we     = md_we;
      end
      default: ;
    endcase
  end

  // EX/MEM register and muldiv control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      md_f           <= '0;
      md_rd          <= '0;
      md_we          <= 1'b0;
      result_MEM     <= '0;
      rd_MEM         <= '0;
      regfile_we_MEM <= 1'b0;
    end else begin
      state          <= state_next;
      result_MEM     <= wb_result;
      rd_MEM         <= wb_rd;
      regfile_we_MEM <= wb_we;
      if (state == IDLE && start) begin
        cnt   <= '0;
        md_f  <= f_in;
        md_rd <= rd_EX;
        md_we <= regfile_we_EX;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: arithmetic reference model checked every
// cycle, plus literal expectations for each instruction issued.
module tb_execute_stage;

  localparam int MC = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc0_EX = 32'h100;
  logic [31:0] pc4_EX = 32'h104;
  logic [3:0]  rd_EX = '0;
  logic [3:0]  alu_operation_EX = '0;
  logic        muldiv_EX = 1'b0;
  logic        regfile_we_EX = 1'b0;
  logic        alu_a_sel_EX = 1'b0;
  logic        alu_b_sel_EX = 1'b0;
  logic [31:0] immediate_EX = '0;
  logic [31:0] rs1_data_EX = '0;
  logic [31:0] rs2_data_EX = '0;
  logic        stall_EX;
  logic [31:0] result_MEM;
  logic [3:0]  rd_MEM;
  logic        regfile_we_MEM;

  always #5 clk = ~clk;

  execute_stage #(.MULDIV_EN(1), .MULDIV_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .pc0_EX(pc0_EX), .pc4_EX(pc4_EX), .rd_EX(rd_EX),
    .alu_operation_EX(alu_operation_EX), .muldiv_EX(muldiv_EX),
    .regfile_we_EX(regfile_we_EX), .alu_a_sel_EX(alu_a_sel_EX),
    .alu_b_sel_EX(alu_b_sel_EX), .immediate_EX(immediate_EX),
    .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX), .stall_EX(stall_EX),
    .result_MEM(result_MEM), .rd_MEM(rd_MEM), .regfile_we_MEM(regfile_we_MEM)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << sh;
      3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> sh;
      7: return $signed(a) >>> sh;
      8: return a | b;
      9: return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input int f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f)
      0: begin p = sa * sb; return p[31:0]; end
      1: begin p = sa * sb; return p[63:32]; end
      2: begin p = sa * ub; return p[63:32]; end
      3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Model: m_left counts cycles until a pending muldiv writes back (0 = free).
  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic [3:0]  m_rd = '0;
  logic [31:0] exp_res = '0;
  logic [3:0]  exp_rd = '0;
  logic        exp_we = 1'b0;
  logic        exp_chk = 1'b1;
  logic        m_start;

  assign m_start = muldiv_EX && regfile_we_EX && (rd_EX != 4'd0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; exp_res = '0; exp_rd = '0; exp_we = 1'b0; exp_chk = 1'b1;
    end else if (m_left == 0) begin
      if (m_start) begin
        m_res = ref_md(int'(alu_operation_EX[2:0]), rs1_data_EX, rs2_data_EX);
        m_rd = rd_EX;
        m_left = MC + 1;
        exp_we = 1'b0; exp_chk = 1'b0;
      end else begin
        exp_res = muldiv_EX ? 32'd0 :
                  ref_alu(int'(alu_operation_EX), alu_a_sel_EX ? pc0_EX : rs1_data_EX,
                          alu_b_sel_EX ? immediate_EX : rs2_data_EX);
        exp_rd = rd_EX; exp_we = regfile_we_EX; exp_chk = 1'b1;
      end
    end else if (m_left == 1) begin
      exp_res = m_res; exp_rd = m_rd; exp_we = 1'b1; exp_chk = 1'b1;
      m_left = 0;
    end else begin
      exp_we = 1'b0; exp_chk = 1'b0;
      m_left--;
    end
  end

  always @(negedge clk) begin
    check("stall_EX", {31'b0, stall_EX},
          {31'b0, rst_n && ((m_left == 0 && m_start) || m_left > 1)});
    check("we_MEM", {31'b0, regfile_we_MEM}, {31'b0, exp_we});
    if (exp_chk) begin
      check("result_MEM", result_MEM, exp_res);
      check("rd_MEM", {28'b0, rd_MEM}, {28'b0, exp_rd});
    end
  end

  // Called just after a rising edge; holds the instruction while stalled.
  task automatic exec(input string name, input logic md, input logic [3:0] op, input logic we,
                      input logic [3:0] rd, input logic asel, input logic bsel,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                      input logic [31:0] lit, input int nstall);
    int n;
    muldiv_EX = md; alu_operation_EX = op; regfile_we_EX = we; rd_EX = rd;
    alu_a_sel_EX = asel; alu_b_sel_EX = bsel;
    rs1_data_EX = a; rs2_data_EX = b; immediate_EX = imm;
    n = 0;
    @(negedge clk);
    while (stall_EX && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL %s timeout: stall still high after %0d cycles, required %0d", name, n, nstall);
    end
    @(posedge clk);
    #1;
    check({name, ".result"}, result_MEM, lit);
    check({name, ".rd"}, {28'b0, rd_MEM}, {28'b0, rd});
    check({name, ".we"}, {31'b0, regfile_we_MEM}, {31'b0, we});
    check({name, ".stall_cycles"}, n, nstall);
  endtask

  initial begin
    int wb;
    repeat (3) @(posedge clk);
    #1;
    check("reset.result", result_MEM, 32'd0);
    check("reset.rd", {28'b0, rd_MEM}, 32'd0);
    check("reset.we", {31'b0, regfile_we_MEM}, 32'd0);
    check("reset.stall", {31'b0, stall_EX}, 32'd0);
    rst_n = 1'b1;

    exec("add_imm", 0, 4'd0, 1, 4'd3, 0, 1, 32'd5, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFE, 0);
    exec("mul",     1, 4'd0, 1, 4'd4, 0, 0, 32'hFFFFFFFF, 32'd3, 32'd0, 32'hFFFFFFFD, MC + 1);
    exec("add_b2b", 0, 4'd0, 1, 4'd5, 0, 0, 32'd10, 32'd20, 32'd0, 32'd30, 0);
    exec("mulhu",   1, 4'd3, 1, 4'd6, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, MC + 1);
    exec("div_ovf", 1, 4'd4, 1, 4'd7, 0, 0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, MC + 1);
    exec("rem_ovf", 1, 4'd6, 1, 4'd7, 0, 0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, MC + 1);
    exec("rem_by0", 1, 4'd6, 1, 4'd8, 0, 0, 32'd7, 32'd0, 32'd0, 32'd7, MC + 1);
    exec("divu_by0",1, 4'd5, 1, 4'd9, 0, 0, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, MC + 1);
    exec("mulh",    1, 4'd1, 1, 4'd2, 0, 0, 32'hFFFFFFFD, 32'd5, 32'd0, 32'hFFFFFFFF, MC + 1);
    exec("mulhsu",  1, 4'd2, 1, 4'd2, 0, 0, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd1, MC + 1);
    exec("div_neg", 1, 4'd4, 1, 4'd1, 1, 1, 32'hFFFFFFF9, 32'd2, 32'd0, 32'hFFFFFFFD, MC + 1);
    exec("rem_neg", 1, 4'd6, 1, 4'd1, 0, 0, 32'hFFFFFFF9, 32'd2, 32'd0, 32'hFFFFFFFF, MC + 1);
    exec("remu",    1, 4'd7, 1, 4'd1, 0, 0, 32'd7, 32'd3, 32'd0, 32'd1, MC + 1);
    exec("divu",    1, 4'd5, 1, 4'd1, 0, 0, 32'd100, 32'd7, 32'd0, 32'd14, MC + 1);
    exec("sub",     0, 4'd1, 1, 4'd2, 0, 0, 32'd5, 32'd7, 32'd0, 32'hFFFFFFFE, 0);
    exec("sll",     0, 4'd2, 1, 4'd2, 0, 0, 32'd1, 32'd33, 32'd0, 32'd2, 0);
    exec("slt",     0, 4'd3, 1, 4'd2, 0, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 0);
    exec("sltu",    0, 4'd4, 1, 4'd2, 0, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 0);
    exec("xor",     0, 4'd5, 1, 4'd2, 0, 0, 32'h0000F0F0, 32'h0000FF00, 32'd0, 32'h00000FF0, 0);
    exec("srl",     0, 4'd6, 1, 4'd2, 0, 0, 32'h80000000, 32'd4, 32'd0, 32'h08000000, 0);
    exec("sra",     0, 4'd7, 1, 4'd2, 0, 0, 32'h80000000, 32'd4, 32'd0, 32'hF8000000, 0);
    exec("or",      0, 4'd8, 1, 4'd2, 0, 0, 32'h000000F0, 32'h0000000F, 32'd0, 32'h000000FF, 0);
    exec("and",     0, 4'd9, 1, 4'd2, 0, 0, 32'h000000F0, 32'h0000003C, 32'd0, 32'h00000030, 0);
    exec("pass_b",  0, 4'd10, 1, 4'd2, 0, 1, 32'd1, 32'd2, 32'h0000ABCD, 32'h0000ABCD, 0);
    exec("op11",    0, 4'd11, 1, 4'd2, 0, 0, 32'd9, 32'd9, 32'd0, 32'd0, 0);
    exec("pc_add",  0, 4'd0, 1, 4'd2, 1, 1, 32'd0, 32'd0, 32'd8, 32'h00000108, 0);
    exec("md_rd0",  1, 4'd0, 1, 4'd0, 0, 0, 32'd5, 32'd6, 32'd0, 32'd0, 0);
    exec("md_bub",  1, 4'd4, 0, 4'd9, 0, 0, 32'd5, 32'd6, 32'd0, 32'd0, 0);

    // Abort a DIV in the middle of its iterations.
    muldiv_EX = 1; alu_operation_EX = 4'd4; regfile_we_EX = 1; rd_EX = 4'd7;
    alu_a_sel_EX = 0; alu_b_sel_EX = 0; rs1_data_EX = 32'd100; rs2_data_EX = 32'd3;
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.result", result_MEM, 32'd0);
    check("abort.rd", {28'b0, rd_MEM}, 32'd0);
    check("abort.we", {31'b0, regfile_we_MEM}, 32'd0);
    check("abort.stall", {31'b0, stall_EX}, 32'd0);
    muldiv_EX = 0; regfile_we_EX = 0; rd_EX = 4'd0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    wb = 0;
    repeat (MC + 8) begin
      @(posedge clk);
      #1;
      if (regfile_we_MEM) wb++;
    end
    check("abort.no_writeback", wb, 0);
    exec("add_after", 0, 4'd0, 1, 4'd3, 0, 0, 32'd40, 32'd2, 32'd0, 32'd42, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
